// File: rtl/obstacle_pkg.sv
// Shared types and constants for the multi-slot obstacle field.
package obstacle_pkg;

  localparam int COORD_W = 10;
  localparam int SPEED_W = 5;
  localparam int SCORE_W = 16;
  localparam int LFSR_W  = 16;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic [COORD_W-1:0] RESET_X = 10'd300;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_FALLING = 1'b1
  } slot_state_e;

  function automatic logic [COORD_W-1:0] fold_x(
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] xmax
  );
    return (v > xmax) ? (v - xmax - 10'd1) : v;
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 16-bit Galois LFSR stepping on enable, with the folded X spawn position.
module obstacle_lfsr
  import obstacle_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  parameter int                XMAX = 610
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  output logic [LFSR_W-1:0]  state_o,
  output logic [COORD_W-1:0] xpos_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS)
                         : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;
  assign xpos_o  = fold_x(lfsr_q[COORD_W-1:0], COORD_W'(XMAX));

endmodule

// File: rtl/obstacle_field_control.sv
// NUM_OBS falling-obstacle slots with spawn timer, collision capture, dodge count.
// Optional speed ramp enabled by defining OBSTACLE_SPEEDUP_EN.
module obstacle_field_control
  import obstacle_pkg::*;
#(
  parameter int          NUM_OBS     = 4,
  parameter int          OBS_W       = 30,
  parameter int          OBS_H       = 30,
  parameter int          SCREEN_W    = SCREEN_W_DEF,
  parameter int          SCREEN_H    = SCREEN_H_DEF,
  parameter int          BASE_SPEED  = 8,
  parameter int          MAX_SPEED   = 16,
  parameter int          RAMP_DODGES = 8,
  parameter int          SPAWN_GAP   = 20,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       game_en,
  input  logic [NUM_OBS-1:0]         collision,
  output logic [COORD_W*NUM_OBS-1:0] obs_x_flat,
  output logic [COORD_W*NUM_OBS-1:0] obs_y_flat,
  output logic [NUM_OBS-1:0]         obs_active,
  output logic [COORD_W-1:0]         obstacle_width,
  output logic [COORD_W-1:0]         obstacle_height,
  output logic [SPEED_W-1:0]         speed,
  output logic                       dodged_pulse,
  output logic [SCORE_W-1:0]         dodged_count
);

  localparam int XMAX = SCREEN_W - OBS_W;
  localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(SCREEN_H - OBS_H);
  localparam int TW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(SPAWN_GAP - 1);

  if (XMAX < 511) begin : g_xmax_chk
    $error("SCREEN_W - OBS_W must be at least 511");
  end
  if (LFSR_SEED == 16'h0) begin : g_seed_chk
    $error("LFSR_SEED must be nonzero");
  end
  if (NUM_OBS < 1 || NUM_OBS > 8 || SPAWN_GAP < 1) begin : g_size_chk
    $error("NUM_OBS must be 1..8 and SPAWN_GAP at least 1");
  end
  if (RAMP_DODGES < 1 || MAX_SPEED < BASE_SPEED ||
      MAX_SPEED > 31) begin : g_ramp_chk
    $error("bad speed ramp parameters");
  end

  slot_state_e                      st_q [NUM_OBS];
  slot_state_e                      st_d [NUM_OBS];
  logic [NUM_OBS-1:0][COORD_W-1:0]  x_q, x_d;
  logic [NUM_OBS-1:0][COORD_W-1:0]  y_q, y_d;
  logic [NUM_OBS-1:0]               hit_q, hit_d;
  logic [NUM_OBS-1:0]               dodge;
  logic [TW-1:0]                    tmr_q, tmr_d;
  logic [SCORE_W-1:0]               cnt_q, cnt_d;
  logic                             pulse_q, pulse_d;
  logic [3:0]                       ndodge;
  logic [SCORE_W:0]                 csum;
  logic [COORD_W:0]                 ysum;
  logic                             spawn;
  logic                             found;
  logic [COORD_W-1:0]               xpos;
  logic [15:0]                      lfsr_unused;

  obstacle_lfsr #(
    .SEED (LFSR_SEED),
    .XMAX (XMAX)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (game_en),
    .state_o (lfsr_unused),
    .xpos_o  (xpos)
  );

  always_comb begin
    st_d   = st_q;
    x_d    = x_q;
    y_d    = y_q;
    hit_d  = hit_q;
    tmr_d  = tmr_q;
    dodge  = '0;
    ndodge = '0;
    ysum   = '0;
    found  = 1'b0;
    spawn  = game_en && (tmr_q == T_LAST);

    for (int i = 0; i < NUM_OBS; i++) begin
      if (st_q[i] == S_FALLING && collision[i]) hit_d[i] = 1'b1;
    end

    if (game_en) begin
      tmr_d = (tmr_q == T_LAST) ? '0 : tmr_q + TW'(1);
      for (int i = 0; i < NUM_OBS; i++) begin
        ysum = {1'b0, y_q[i]} + {{(COORD_W+1-SPEED_W){1'b0}}, speed};
        if (st_q[i] == S_FALLING) begin
          if (hit_q[i] || collision[i]) begin
            st_d[i]  = S_IDLE;
            hit_d[i] = 1'b0;
          end else if (ysum > Y_LIM) begin
            st_d[i]  = S_IDLE;
            hit_d[i] = 1'b0;
            dodge[i] = 1'b1;
          end else begin
            y_d[i] = ysum[COORD_W-1:0];
          end
        end
      end
    end

    // Only slots idle at the start of the tick are spawn candidates
    for (int i = 0; i < NUM_OBS; i++) begin
      if (spawn && !found && st_q[i] == S_IDLE) begin
        found    = 1'b1;
        st_d[i]  = S_FALLING;
        x_d[i]   = xpos;
        y_d[i]   = '0;
        hit_d[i] = 1'b0;
      end
    end

    for (int i = 0; i < NUM_OBS; i++) begin
      ndodge = ndodge + {3'b0, dodge[i]};
    end
    csum    = {1'b0, cnt_q} + {{(SCORE_W-3){1'b0}}, ndodge};
    cnt_d   = csum[SCORE_W] ? '1 : csum[SCORE_W-1:0];
    pulse_d = |dodge;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OBS; i++) st_q[i] <= S_IDLE;
      x_q     <= {NUM_OBS{RESET_X}};
      y_q     <= '0;
      hit_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hit_q   <= hit_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef OBSTACLE_SPEEDUP_EN
  logic [SPEED_W-1:0] spd_q, spd_d;
  logic [15:0]        ramp_q, ramp_d, rsum;

  always_comb begin
    spd_d  = spd_q;
    ramp_d = ramp_q;
    rsum   = ramp_q + {12'b0, ndodge};
    if (game_en) begin
      if (rsum >= 16'(RAMP_DODGES)) begin
        // At most one speed step per tick, however many dodges landed
        ramp_d = rsum - 16'(RAMP_DODGES);
        if (ramp_d >= 16'(RAMP_DODGES)) ramp_d = 16'(RAMP_DODGES - 1);
        if (spd_q < SPEED_W'(MAX_SPEED)) spd_d = spd_q + SPEED_W'(1);
      end else begin
        ramp_d = rsum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_q  <= SPEED_W'(BASE_SPEED);
      ramp_q <= '0;
    end else begin
      spd_q  <= spd_d;
      ramp_q <= ramp_d;
    end
  end

  assign speed = spd_q;
`else
  assign speed = SPEED_W'(BASE_SPEED);
`endif

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_act
    assign obs_active[g] = (st_q[g] == S_FALLING);
  end

  assign obs_x_flat      = x_q;
  assign obs_y_flat      = y_q;
  assign obstacle_width  = COORD_W'(OBS_W);
  assign obstacle_height = COORD_W'(OBS_H);
  assign dodged_pulse    = pulse_q;
  assign dodged_count    = cnt_q;

endmodule

// File: tb/tb_obstacle_field_control.sv
// Directed bench for obstacle_field_control: default slot and a gap-3 slot.
module tb_obstacle_field_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic game_en = 1'b0;
  logic [3:0] coll = '0;
  logic [3:0] coll2 = '0;

  logic [3:0][9:0] ox, oy, ox2, oy2;
  logic [3:0] act, act2;
  logic [9:0] w, h, w2, h2;
  logic [4:0] spd, spd2;
  logic pulse, pulse2;
  logic [15:0] cnt, cnt2;

  int nvec = 0;
  int nmis = 0;

  always #10 clk = ~clk;

  obstacle_field_control dut (
    .clk(clk), .rst(rst), .game_en(game_en), .collision(coll),
    .obs_x_flat(ox), .obs_y_flat(oy), .obs_active(act),
    .obstacle_width(w), .obstacle_height(h), .speed(spd),
    .dodged_pulse(pulse), .dodged_count(cnt)
  );

  obstacle_field_control #(.SPAWN_GAP(3)) dut2 (
    .clk(clk), .rst(rst), .game_en(game_en), .collision(coll2),
    .obs_x_flat(ox2), .obs_y_flat(oy2), .obs_active(act2),
    .obstacle_width(w2), .obstacle_height(h2), .speed(spd2),
    .dodged_pulse(pulse2), .dodged_count(cnt2)
  );

  function automatic logic [15:0] lafter(input int n);
    logic [15:0] s;
    s = 16'hACE1;
    for (int k = 0; k < n; k++)
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    return s;
  endfunction

  function automatic logic [9:0] tfold(input logic [15:0] s);
    logic [9:0] v;
    v = s[9:0];
    return (v > 10'd610) ? (v - 10'd611) : v;
  endfunction

  task automatic tick();
    game_en = 1'b1;
    @(posedge clk);
    #1 game_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    game_en = 1'b0;
    coll = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (act !== 4'b0000) begin nmis++; $display("FAIL rst_act got %b exp 0000", act); end nvec++;
    if (ox !== {4{10'd300}}) begin nmis++; $display("FAIL rst_x got %h exp all 300", ox); end nvec++;
    if (oy !== '0) begin nmis++; $display("FAIL rst_y got %h exp 0", oy); end nvec++;
    if (spd !== 5'd8) begin nmis++; $display("FAIL rst_speed got %0d exp 8", spd); end nvec++;
    if (cnt !== 16'd0) begin nmis++; $display("FAIL rst_count got %0d exp 0", cnt); end nvec++;
    if (pulse !== 1'b0) begin nmis++; $display("FAIL rst_pulse got %b exp 0", pulse); end nvec++;
    if (w !== 10'd30 || h !== 10'd30) begin nmis++; $display("FAIL rst_dims got %0d/%0d exp 30/30", w, h); end nvec++;
  endtask

  task automatic test_spawn();
    logic [9:0] xe;
    ticks(19);
    if (act !== 4'b0000) begin nmis++; $display("FAIL spawn_early got %b exp 0000", act); end nvec++;
    tick();
    xe = tfold(lafter(19));
    if (act !== 4'b0001) begin nmis++; $display("FAIL spawn_act got %b exp 0001", act); end nvec++;
    if (oy[0] !== 10'd0) begin nmis++; $display("FAIL spawn_y got %0d exp 0", oy[0]); end nvec++;
    if (ox[0] !== xe) begin nmis++; $display("FAIL spawn_x got %0d exp %0d", ox[0], xe); end nvec++;
  endtask

  task automatic test_fall_dodge();
    for (int k = 1; k <= 56; k++) begin
      tick();
      if (oy[0] !== 10'(8 * k)) begin nmis++; $display("FAIL fall_y k=%0d got %0d exp %0d", k, oy[0], 8 * k); end nvec++;
    end
    if (pulse !== 1'b0 || act[0] !== 1'b1) begin nmis++; $display("FAIL fall_pre got p=%b a=%b exp p=0 a=1", pulse, act[0]); end nvec++;
    tick();
    if (act[0] !== 1'b0) begin nmis++; $display("FAIL dodge_act got %b exp 0", act[0]); end nvec++;
    if (oy[0] !== 10'd448) begin nmis++; $display("FAIL dodge_y got %0d exp 448", oy[0]); end nvec++;
    if (pulse !== 1'b1) begin nmis++; $display("FAIL dodge_pulse got %b exp 1", pulse); end nvec++;
    if (cnt !== 16'd1) begin nmis++; $display("FAIL dodge_count got %0d exp 1", cnt); end nvec++;
    if (act[2:1] !== 2'b11) begin nmis++; $display("FAIL dodge_others got %b exp 11", act[2:1]); end nvec++;
    @(posedge clk); #1;
    if (pulse !== 1'b0) begin nmis++; $display("FAIL dodge_pulse_len got %b exp 0", pulse); end nvec++;
    if (cnt !== 16'd1) begin nmis++; $display("FAIL dodge_hold got %0d exp 1", cnt); end nvec++;
    if (spd !== 5'd8) begin nmis++; $display("FAIL dodge_speed got %0d exp 8", spd); end nvec++;
  endtask

  task automatic test_collision();
    logic [9:0] xe;
    do_reset();
    ticks(30);
    coll = 4'b0001;
    @(posedge clk);
    #1 coll = 4'b0000;
    if (act[0] !== 1'b1 || oy[0] !== 10'd80) begin nmis++; $display("FAIL hit_pre got a=%b y=%0d exp a=1 y=80", act[0], oy[0]); end nvec++;
    tick();
    if (act[0] !== 1'b0) begin nmis++; $display("FAIL hit_act got %b exp 0", act[0]); end nvec++;
    if (oy[0] !== 10'd80) begin nmis++; $display("FAIL hit_y got %0d exp 80", oy[0]); end nvec++;
    if (cnt !== 16'd0 || pulse !== 1'b0) begin nmis++; $display("FAIL hit_nododge got c=%0d p=%b exp c=0 p=0", cnt, pulse); end nvec++;
    coll = 4'b1111;
    @(posedge clk);
    #1 coll = 4'b0000;
    ticks(9);
    xe = tfold(lafter(39));
    if (act !== 4'b0001 || ox[0] !== xe) begin nmis++; $display("FAIL hit_respawn got a=%b x=%0d exp a=0001 x=%0d", act, ox[0], xe); end nvec++;
    tick();
    if (act !== 4'b0001 || oy[0] !== 10'd8) begin nmis++; $display("FAIL idle_coll_ign got a=%b y=%0d exp a=0001 y=8", act, oy[0]); end nvec++;
    coll = 4'b0001;
    tick();
    coll = 4'b0000;
    if (act[0] !== 1'b0 || oy[0] !== 10'd8) begin nmis++; $display("FAIL live_hit got a=%b y=%0d exp a=0 y=8", act[0], oy[0]); end nvec++;
  endtask

  task automatic test_all_busy();
    logic [9:0] x0, x0b;
    do_reset();
    x0 = tfold(lafter(2));
    x0b = tfold(lafter(62));
    ticks(12);
    if (act2 !== 4'b1111) begin nmis++; $display("FAIL busy_fill got %b exp 1111", act2); end nvec++;
    ticks(3);
    if (act2 !== 4'b1111 || oy2[0] !== 10'd96) begin nmis++; $display("FAIL busy_skip got a=%b y=%0d exp a=1111 y=96", act2, oy2[0]); end nvec++;
    if (ox2[0] !== x0) begin nmis++; $display("FAIL busy_x got %0d exp %0d", ox2[0], x0); end nvec++;
    ticks(45);
    if (act2 !== 4'b1110 || oy2[0] !== 10'd448) begin nmis++; $display("FAIL busy_retire got a=%b y=%0d exp a=1110 y=448", act2, oy2[0]); end nvec++;
    if (pulse2 !== 1'b1 || cnt2 !== 16'd1) begin nmis++; $display("FAIL busy_dodge got p=%b c=%0d exp p=1 c=1", pulse2, cnt2); end nvec++;
    ticks(3);
    if (act2 !== 4'b1101 || oy2[0] !== 10'd0) begin nmis++; $display("FAIL busy_wrap got a=%b y=%0d exp a=1101 y=0", act2, oy2[0]); end nvec++;
    if (ox2[0] !== x0b || oy2[1] !== 10'd448 || cnt2 !== 16'd2) begin nmis++; $display("FAIL busy_respawn got x=%0d y1=%0d c=%0d exp x=%0d y1=448 c=2", ox2[0], oy2[1], cnt2, x0b); end nvec++;
  endtask

  task automatic test_speed();
    int guard;
    logic [4:0] e8, e64;
`ifdef OBSTACLE_SPEEDUP_EN
    e8 = 5'd9;
    e64 = 5'd16;
`else
    e8 = 5'd8;
    e64 = 5'd8;
`endif
    do_reset();
    guard = 0;
    while (cnt2 < 16'd8 && guard < 3000) begin tick(); guard++; end
    if (guard >= 3000) begin nmis++; $display("FAIL speed_wait8 got %0d exp 8", cnt2); end nvec++;
    if (spd2 !== e8) begin nmis++; $display("FAIL speed_8 got %0d exp %0d", spd2, e8); end nvec++;
    while (cnt2 < 16'd64 && guard < 3000) begin tick(); guard++; end
    if (spd2 !== e64) begin nmis++; $display("FAIL speed_64 got %0d exp %0d", spd2, e64); end nvec++;
    while (cnt2 < 16'd72 && guard < 3000) begin tick(); guard++; end
    if (guard >= 3000) begin nmis++; $display("FAIL speed_wait72 got %0d exp 72", cnt2); end nvec++;
    if (spd2 !== e64) begin nmis++; $display("FAIL speed_72 got %0d exp %0d", spd2, e64); end nvec++;
  endtask

  task automatic test_midfall_reset();
    logic [9:0] xe;
    do_reset();
    ticks(60);
    if (act !== 4'b0111) begin nmis++; $display("FAIL mid_pre got %b exp 0111", act); end nvec++;
    #4 rst = 1'b1;
    #1;
    if (act !== 4'b0000 || act2 !== 4'b0000) begin nmis++; $display("FAIL mid_act got %b/%b exp 0000", act, act2); end nvec++;
    if (ox !== {4{10'd300}} || oy !== '0) begin nmis++; $display("FAIL mid_xy got x=%h y=%h exp all 300 and 0", ox, oy); end nvec++;
    @(posedge clk);
    #1 rst = 1'b0;
    ticks(19);
    if (act !== 4'b0000) begin nmis++; $display("FAIL mid_early got %b exp 0000", act); end nvec++;
    tick();
    xe = tfold(lafter(19));
    if (act !== 4'b0001 || ox[0] !== xe) begin nmis++; $display("FAIL mid_respawn got a=%b x=%0d exp a=0001 x=%0d", act, ox[0], xe); end nvec++;
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_fall_dodge();
    test_collision();
    test_all_busy();
    test_speed();
    test_midfall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
